// File: rtl/nf_pkg.sv
// Shared types and helpers for the neuron fetch sequencer.
package nf_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StDrain,
    StDone
  } nf_state_e;

  // Ceiling log2 for parameter elaboration.
  function automatic int unsigned nf_clog2(input int unsigned value);
    int unsigned res;
    int unsigned pow;
    res = 0;
    pow = 1;
    while (pow < value) begin
      pow = pow << 1;
      res++;
    end
    return res;
  endfunction

  // A window must fit in the bank set, in the picture, and in the marker delay line.
  function automatic logic nf_cfg_legal(input int unsigned span,
                                        input int unsigned pic_height,
                                        input int unsigned channels,
                                        input int unsigned depth,
                                        input int unsigned max_delay);
    return (span + 1 <= channels) && (span <= pic_height) &&
           (span + 1 <= max_delay) && (pic_height < depth);
  endfunction

endpackage

// File: rtl/nf_marker_delay.sv
// Variable-tap delay line for the window_last / column_switch stage markers.
module nf_marker_delay
  import nf_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TAP_W = nf_clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             layer_reset_n,
  input  logic             shift_en_i,
  input  logic             clear_i,
  input  logic             window_last_i,
  input  logic             column_switch_i,
  input  logic [TAP_W-1:0] tap_i,
  output logic             window_last_o,
  output logic             column_switch_o
);

  logic [DEPTH-1:0] wl_q;
  logic [DEPTH-1:0] cs_q;

  // Shift register; cleared at layer start so stale markers never reach a longer tap.
  always_ff @(posedge clk or negedge layer_reset_n) begin
    if (!layer_reset_n) begin
      wl_q <= '0;
      cs_q <= '0;
    end else if (clear_i) begin
      wl_q <= '0;
      cs_q <= '0;
    end else if (shift_en_i) begin
      wl_q <= {wl_q[DEPTH-2:0], window_last_i};
      cs_q <= {cs_q[DEPTH-2:0], column_switch_i};
    end
  end

  // Tap N returns the marker entered N shifts ago.
  always_comb begin
    window_last_o   = 1'b0;
    column_switch_o = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (tap_i == TAP_W'(i + 1)) begin
        window_last_o   = wl_q[i];
        column_switch_o = cs_q[i];
      end
    end
  end

endmodule

// File: rtl/neuron_fetch_sequencer.sv
// Address / channel sequencer walking a KxK (or Kx1) window down each cached column.
module neuron_fetch_sequencer
  import nf_pkg::*;
#(
  parameter int unsigned CACHE_CHANNELS = 8,
  parameter int unsigned CACHE_DEPTH    = 64,
  parameter int unsigned CFG_W          = 4,
  parameter int unsigned MAX_DELAY      = 8,
  localparam int unsigned ADDR_W        = nf_clog2(CACHE_DEPTH)
) (
  input  logic                      clk,
  input  logic                      layer_reset_n,
  input  logic                      start_i,
  input  logic                      stall_i,
  input  logic                      fully_connect_en_i,
  input  logic [CFG_W-1:0]          filter_width_i,
  input  logic [CFG_W-1:0]          filter_height_i,
  input  logic [CFG_W-1:0]          stride_i,
  input  logic [ADDR_W-1:0]         picture_height_i,
  input  logic [CFG_W-1:0]          num_columns_i,
  output logic                      cache_rd_o,
  output logic [ADDR_W-1:0]         address_o,
  output logic [CACHE_CHANNELS-1:0] channel_sel_o,
  output logic                      window_last_o,
  output logic                      column_switch_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      cfg_err_o
);

  localparam int unsigned TAP_W = nf_clog2(MAX_DELAY + 1);
  localparam int unsigned SUM_W = ADDR_W + 1;

  nf_state_e                 state_q, state_d;
  logic [ADDR_W-1:0]         begin_q, begin_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic [CACHE_CHANNELS-1:0] mask_q, mask_d;
  logic [CFG_W-1:0]          col_q, col_d;
  logic [TAP_W-1:0]          drain_q, drain_d;
  logic                      cfg_err_q, cfg_err_d;

  // Configuration captured at start
  logic [CFG_W-1:0]          span_q;
  logic [CFG_W-1:0]          stride_q;
  logic [CFG_W-1:0]          ncol_q;
  logic [ADDR_W-1:0]         ph_q;
  logic [TAP_W-1:0]          tap_q;

  logic [CFG_W-1:0]          span_in;
  logic                      cfg_legal;
  logic                      start_ok;
  logic [CACHE_CHANNELS-1:0] init_mask;
  logic [CACHE_CHANNELS-1:0] rot_mask;
  logic [SUM_W-1:0]          win_end_addr;
  logic [SUM_W-1:0]          next_begin;
  logic [SUM_W-1:0]          next_win_end;
  logic                      raw_wl, raw_cs, rd;
  logic                      shift_en;

  // Start-time decode: window span, legality and the MSB-aligned initial bank mask.
  always_comb begin
    span_in   = fully_connect_en_i ? filter_height_i : filter_width_i;
    cfg_legal = nf_cfg_legal(32'(span_in), 32'(picture_height_i), CACHE_CHANNELS,
                             CACHE_DEPTH, MAX_DELAY);
    start_ok  = (state_q == StIdle) && start_i && cfg_legal;
    for (int unsigned i = 0; i < CACHE_CHANNELS; i++) begin
      if (fully_connect_en_i) init_mask[i] = (i == CACHE_CHANNELS - 1);
      else                    init_mask[i] = (i + 32'(span_in) >= CACHE_CHANNELS - 1);
    end
  end

  // Column-end mask: rotate right by the stride, modulo the bank count.
  always_comb begin
    int unsigned rot_sh;
    rot_sh = (32'(stride_q) + 1) % CACHE_CHANNELS;
    for (int unsigned i = 0; i < CACHE_CHANNELS; i++) begin
      rot_mask[i] = mask_q[(i + rot_sh) % CACHE_CHANNELS];
    end
  end

  // Window geometry in ADDR_W+1 bits so begin+S+span cannot wrap.
  always_comb begin
    win_end_addr = SUM_W'(begin_q) + SUM_W'(span_q);
    next_begin   = SUM_W'(begin_q) + SUM_W'(stride_q) + SUM_W'(1);
    next_win_end = next_begin + SUM_W'(span_q);
  end

  // Next-state, address walk and raw marker generation.
  always_comb begin
    state_d   = state_q;
    begin_d   = begin_q;
    addr_d    = addr_q;
    mask_d    = mask_q;
    col_d     = col_q;
    drain_d   = drain_q;
    cfg_err_d = cfg_err_q;
    raw_wl    = 1'b0;
    raw_cs    = 1'b0;
    rd        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          cfg_err_d = ~cfg_legal;
          if (cfg_legal) begin
            state_d = StFetch;
            begin_d = '0;
            addr_d  = '0;
            mask_d  = init_mask;
            col_d   = '0;
            drain_d = '0;
          end else begin
            state_d = StDone;
          end
        end
      end
      StFetch: begin
        if (!stall_i) begin
          rd = 1'b1;
          if (SUM_W'(addr_q) != win_end_addr) begin
            addr_d = addr_q + ADDR_W'(1);
          end else begin
            raw_wl = 1'b1;
            if (next_win_end <= SUM_W'(ph_q)) begin
              begin_d = ADDR_W'(next_begin);
              addr_d  = ADDR_W'(next_begin);
            end else begin
              // Column end wins over the window advance
              raw_cs  = 1'b1;
              begin_d = '0;
              addr_d  = '0;
              mask_d  = rot_mask;
              if (col_q == ncol_q) begin
                col_d   = '0;
                // The last read counts as the first drain cycle, so done_o
                // lines up with the final delayed marker.
                drain_d = TAP_W'(1);
                state_d = (tap_q == TAP_W'(1)) ? StDone : StDrain;
              end else begin
                col_d = col_q + CFG_W'(1);
              end
            end
          end
        end
      end
      StDrain: begin
        if (!stall_i) begin
          if (drain_q == tap_q - TAP_W'(1)) state_d = StDone;
          else                              drain_d = drain_q + TAP_W'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk or negedge layer_reset_n) begin
    if (!layer_reset_n) begin
      state_q   <= StIdle;
      begin_q   <= '0;
      addr_q    <= '0;
      mask_q    <= '0;
      col_q     <= '0;
      drain_q   <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      begin_q   <= begin_d;
      addr_q    <= addr_d;
      mask_q    <= mask_d;
      col_q     <= col_d;
      drain_q   <= drain_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  // Configuration latch; later cfg_* changes are invisible to the running layer.
  always_ff @(posedge clk or negedge layer_reset_n) begin
    if (!layer_reset_n) begin
      span_q   <= '0;
      stride_q <= '0;
      ncol_q   <= '0;
      ph_q     <= '0;
      tap_q    <= '0;
    end else if (start_ok) begin
      span_q   <= span_in;
      stride_q <= stride_i;
      ncol_q   <= num_columns_i;
      ph_q     <= picture_height_i;
      tap_q    <= TAP_W'(span_in) + TAP_W'(1);
    end
  end

  // Stall freezes the markers except in DONE, where it is ignored.
  assign shift_en = !stall_i || (state_q == StDone);

  nf_marker_delay #(
    .DEPTH (MAX_DELAY),
    .TAP_W (TAP_W)
  ) u_marker_delay (
    .clk             (clk),
    .layer_reset_n   (layer_reset_n),
    .shift_en_i      (shift_en),
    .clear_i         (start_ok),
    .window_last_i   (raw_wl),
    .column_switch_i (raw_cs),
    .tap_i           (tap_q),
    .window_last_o   (window_last_o),
    .column_switch_o (column_switch_o)
  );

  assign cache_rd_o    = rd;
  assign address_o     = addr_q;
  assign channel_sel_o = mask_q;
  assign busy_o        = (state_q == StFetch) || (state_q == StDrain);
  assign done_o        = (state_q == StDone);
  assign cfg_err_o     = cfg_err_q;

endmodule

// File: tb/tb_neuron_fetch_sequencer.sv
// Randomized bench for neuron_fetch_sequencer against a window-walk reference model.
module tb_neuron_fetch_sequencer;

  localparam int unsigned CH    = 8;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned CW    = 4;
  localparam int unsigned MAXD  = 8;
  localparam int unsigned AW    = 6;

  logic          clk;
  logic          layer_reset_n;
  logic          start_i;
  logic          stall_i;
  logic          fully_connect_en_i;
  logic [CW-1:0] filter_width_i;
  logic [CW-1:0] filter_height_i;
  logic [CW-1:0] stride_i;
  logic [AW-1:0] picture_height_i;
  logic [CW-1:0] num_columns_i;
  logic          cache_rd_o;
  logic [AW-1:0] address_o;
  logic [CH-1:0] channel_sel_o;
  logic          window_last_o;
  logic          column_switch_o;
  logic          busy_o;
  logic          done_o;
  logic          cfg_err_o;

  neuron_fetch_sequencer #(
    .CACHE_CHANNELS (CH),
    .CACHE_DEPTH    (DEPTH),
    .CFG_W          (CW),
    .MAX_DELAY      (MAXD)
  ) dut (
    .clk                (clk),
    .layer_reset_n      (layer_reset_n),
    .start_i            (start_i),
    .stall_i            (stall_i),
    .fully_connect_en_i (fully_connect_en_i),
    .filter_width_i     (filter_width_i),
    .filter_height_i    (filter_height_i),
    .stride_i           (stride_i),
    .picture_height_i   (picture_height_i),
    .num_columns_i      (num_columns_i),
    .cache_rd_o         (cache_rd_o),
    .address_o          (address_o),
    .channel_sel_o      (channel_sel_o),
    .window_last_o      (window_last_o),
    .column_switch_o    (column_switch_o),
    .busy_o             (busy_o),
    .done_o             (done_o),
    .cfg_err_o          (cfg_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_tests;
  int unsigned n_fail;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [CH-1:0] mask;
    logic          wl;
    logic          cs;
  } rd_t;

  rd_t reads[$];

  // Bank mask for column c: initial mask rotated right by c*S positions.
  function automatic logic [CH-1:0] model_mask(input bit fc, input int span, input int k);
    logic [CH-1:0]   base;
    logic [2*CH-1:0] dbl;
    base = fc ? 8'h80 : 8'hFF << (7 - span);
    dbl  = {base, base};
    dbl  = dbl >> k;
    return dbl[CH-1:0];
  endfunction

  // Every read of a layer, in order: windows of span+1 rows stepping by S down each column.
  task automatic build_reads(input bit fc, input int fw, input int fh, input int sm1,
                             input int ph, input int ncol);
    int span;
    int s;
    rd_t r;
    span = fc ? fh : fw;
    s    = sm1 + 1;
    reads.delete();
    for (int c = 0; c <= ncol; c++) begin
      for (int b = 0; b + span <= ph; b += s) begin
        for (int a = b; a <= b + span; a++) begin
          r.addr = AW'(a);
          r.mask = model_mask(fc, span, (c * s) % CH);
          r.wl   = (a == b + span);
          r.cs   = (a == b + span) && (b + s + span > ph);
          reads.push_back(r);
        end
      end
    end
  endtask

  // Runs one legal layer. stall_mode: 0 none, 1 random, 2 five cycles at the second read.
  task automatic run_layer(input bit fc, input int fw, input int fh, input int sm1,
                           input int ph, input int ncol, input int stall_mode);
    int  r_cnt;
    int  d;
    int  m;
    int  stall_left;
    bit  sdone;
    bit  fin;
    bit  st;
    logic exp_wl;
    logic exp_cs;
    build_reads(fc, fw, fh, sm1, ph, ncol);
    r_cnt = reads.size();
    d     = (fc ? fh : fw) + 1;
    @(posedge clk); #1;
    fully_connect_en_i = fc;
    filter_width_i     = CW'(fw);
    filter_height_i    = CW'(fh);
    stride_i           = CW'(sm1);
    picture_height_i   = AW'(ph);
    num_columns_i      = CW'(ncol);
    start_i            = 1'b1;
    stall_i            = 1'b0;
    @(posedge clk); #1;
    start_i = 1'b0;
    m = 0; stall_left = 0; sdone = 0; fin = 0;
    for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
      st = 1'b0;
      // Scramble cfg and pulse start mid-layer; both must be ignored.
      fully_connect_en_i = 1'($urandom_range(0, 1));
      filter_width_i     = CW'($urandom_range(0, 15));
      filter_height_i    = CW'($urandom_range(0, 15));
      stride_i           = CW'($urandom_range(0, 15));
      picture_height_i   = AW'($urandom_range(0, 63));
      num_columns_i      = CW'($urandom_range(0, 15));
      if (m != r_cnt + d - 1) begin
        if (stall_mode == 1) st = ($urandom_range(0, 3) == 0);
        else if (stall_mode == 2) begin
          if (!sdone && m == 1) begin stall_left = 5; sdone = 1; end
          if (stall_left > 0) begin st = 1'b1; stall_left--; end
        end
        start_i = ($urandom_range(0, 7) == 0);
      end else begin
        start_i = 1'b0;
      end
      stall_i = st;
      @(negedge clk);
      if (m == r_cnt + d - 1) begin
        check_val("done_pulse", 32'(done_o), 1);
        check_val("busy_in_done", 32'(busy_o), 0);
        check_val("rd_in_done", 32'(cache_rd_o), 0);
      end else begin
        check_val("done_early", 32'(done_o), 0);
        check_val("busy", 32'(busy_o), 1);
        if (m < r_cnt) begin
          check_val("cache_rd", 32'(cache_rd_o), 32'(!st));
          check_val("address", 32'(address_o), 32'(reads[m].addr));
          check_val("channel_sel", 32'(channel_sel_o), 32'(reads[m].mask));
        end else begin
          check_val("rd_in_drain", 32'(cache_rd_o), 0);
        end
      end
      // Marker output reflects the raw marker of d non-stalled cycles earlier.
      exp_wl = (m >= d) ? reads[m-d].wl : 1'b0;
      exp_cs = (m >= d) ? reads[m-d].cs : 1'b0;
      check_val("window_last", 32'(window_last_o), 32'(exp_wl));
      check_val("column_switch", 32'(column_switch_o), 32'(exp_cs));
      check_val("cfg_err_clear", 32'(cfg_err_o), 0);
      if (m == r_cnt + d - 1) fin = 1;
      else if (!st) m++;
      if (!fin) begin
        @(posedge clk); #1;
      end
    end
    check_val("layer_completes", 32'(fin), 1);
    @(posedge clk); #1;
    start_i = 1'b0;
    stall_i = 1'b0;
    @(negedge clk);
    check_val("done_one_cycle", 32'(done_o), 0);
    check_val("idle_not_busy", 32'(busy_o), 0);
  endtask

  task automatic run_illegal(input bit fc, input int fw, input int fh, input int ph);
    @(posedge clk); #1;
    fully_connect_en_i = fc;
    filter_width_i     = CW'(fw);
    filter_height_i    = CW'(fh);
    stride_i           = '0;
    picture_height_i   = AW'(ph);
    num_columns_i      = '0;
    start_i            = 1'b1;
    stall_i            = 1'b0;
    @(negedge clk);
    check_val("illegal_no_rd_start", 32'(cache_rd_o), 0);
    @(posedge clk); #1;
    start_i = 1'b0;
    @(negedge clk);
    check_val("illegal_done", 32'(done_o), 1);
    check_val("illegal_err", 32'(cfg_err_o), 1);
    check_val("illegal_no_rd", 32'(cache_rd_o), 0);
    check_val("illegal_not_busy", 32'(busy_o), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("illegal_done_once", 32'(done_o), 0);
      check_val("illegal_err_sticky", 32'(cfg_err_o), 1);
      check_val("illegal_idle_rd", 32'(cache_rd_o), 0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_rd"}, 32'(cache_rd_o), 0);
    check_val({tag, "_addr"}, 32'(address_o), 0);
    check_val({tag, "_mask"}, 32'(channel_sel_o), 0);
    check_val({tag, "_wl"}, 32'(window_last_o), 0);
    check_val({tag, "_cs"}, 32'(column_switch_o), 0);
    check_val({tag, "_busy"}, 32'(busy_o), 0);
    check_val({tag, "_done"}, 32'(done_o), 0);
    check_val({tag, "_err"}, 32'(cfg_err_o), 0);
  endtask

  initial begin
    int span;
    int ph;
    bit fc;
    n_tests            = 0;
    n_fail             = 0;
    layer_reset_n      = 1'b0;
    start_i            = 1'b0;
    stall_i            = 1'b0;
    fully_connect_en_i = 1'b0;
    filter_width_i     = '0;
    filter_height_i    = '0;
    stride_i           = '0;
    picture_height_i   = '0;
    num_columns_i      = '0;
    #12;
    check_all_zero("reset");
    @(posedge clk); #1;
    layer_reset_n = 1'b1;

    // Directed cases
    run_layer(0, 2, 0, 0, 4, 0, 0);   // basic 3x3
    run_layer(0, 1, 0, 1, 5, 1, 0);   // stride 2, two columns with rotation
    run_layer(1, 9, 3, 0, 3, 0, 0);   // fully connected, fw ignored
    run_layer(0, 2, 0, 0, 4, 0, 2);   // five-cycle stall at address 1
    run_illegal(0, 5, 0, 3);          // window taller than picture
    run_layer(0, 2, 0, 0, 4, 0, 0);   // legal start clears cfg_err
    run_illegal(1, 0, 9, 12);         // window wider than the bank set
    run_layer(0, 0, 0, 0, 0, 0, 1);   // 1x1 window, single row

    // Reset in the middle of FETCH
    @(posedge clk); #1;
    fully_connect_en_i = 1'b0;
    filter_width_i     = 4'd2;
    stride_i           = 4'd0;
    picture_height_i   = 6'd9;
    num_columns_i      = 4'd2;
    start_i            = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check_val("pre_reset_busy", 32'(busy_o), 1);
    layer_reset_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(posedge clk); #1;
    layer_reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_val("no_done_after_reset", 32'(done_o), 0);
      check_val("idle_after_reset", 32'(busy_o), 0);
    end
    run_layer(0, 2, 0, 0, 4, 0, 0);

    // Random legal layers
    for (int t = 0; t < 24; t++) begin
      fc   = 1'($urandom_range(0, 1));
      span = int'($urandom_range(0, 7));
      ph   = span + int'($urandom_range(0, 12));
      if (fc) run_layer(1, int'($urandom_range(0, 15)), span, int'($urandom_range(0, 3)), ph,
                        int'($urandom_range(0, 3)), int'($urandom_range(0, 1)));
      else    run_layer(0, span, int'($urandom_range(0, 15)), int'($urandom_range(0, 3)), ph,
                        int'($urandom_range(0, 3)), int'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
